// File: rtl/shift_pkg.sv
// Shared constants for the shift_reg_n datapath register.
// Mode encodings and direction values used by the top level and shift_step.
package shift_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage : shift_pkg

// File: rtl/shift_reg_n_shift_step.sv
// shift_step: combinational one-bit shifter shared by the single-shift (ena)
// path and the counted-sequence path of shift_reg_n.
// Optional feature macro: SHIFT_ROTATE_EN (when undefined, mode 10 fills
// from sin exactly like logical mode and no rotate logic is built).
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_dir,
  input  logic [1:0]       i_mode,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_bit
);

  logic w_out;
  logic w_fill;

  // Select the departing bit, the fill bit for the mode, and form the next value.
  always_comb begin
    w_out  = 1'b0;
    w_fill = 1'b0;
    o_q    = i_q;

    if (i_dir == DIR_LEFT) begin
      w_out = i_q[WIDTH-1];
    end else begin
      w_out = i_q[0];
    end

    case (i_mode)
      MODE_ARITH: begin
        // Arithmetic right keeps the sign; arithmetic left shifts in zero.
        if (i_dir == DIR_LEFT) begin
          w_fill = 1'b0;
        end else begin
          w_fill = i_q[WIDTH-1];
        end
      end
`ifdef SHIFT_ROTATE_EN
      MODE_ROT: begin
        w_fill = w_out;
      end
`endif
      default: begin
        // Logical, reserved, and (without rotate support) mode 10.
        w_fill = i_sin;
      end
    endcase

    if (i_dir == DIR_LEFT) begin
      o_q = {i_q[WIDTH-2:0], w_fill};
    end else begin
      o_q = {w_fill, i_q[WIDTH-1:1]};
    end

    o_bit = w_out;
  end

endmodule : shift_step

// File: rtl/shift_reg_n.sv
// shift_reg_n: parametrised shift register with single-step shifts, a
// counted multi-step shift command (busy/done handshake) and a registered
// serial output. Load has highest priority and aborts a running sequence.
// Optional feature macro: SHIFT_ROTATE_EN (enables rotate for mode 10).
module shift_reg_n
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ena,
  input  logic             start,
  input  logic [AW-1:0]    amount,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] CNT_MAX = AW'(WIDTH);
  localparam logic [AW-1:0] CNT_ONE = AW'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;
  logic [AW-1:0]    r_cnt;
  logic             r_dir;
  logic [1:0]       r_mode;

  logic [AW-1:0]    w_amt_sat;
  logic             w_step_dir;
  logic [1:0]       w_step_mode;
  logic [WIDTH-1:0] w_next_q;
  logic             w_out_bit;

  // Saturate the requested step count and pick live or latched shift controls.
  always_comb begin
    w_amt_sat   = amount;
    w_step_dir  = dir;
    w_step_mode = mode;

    if (amount > CNT_MAX) begin
      w_amt_sat = CNT_MAX;
    end else begin
      w_amt_sat = amount;
    end

    // A running sequence uses the controls captured at start.
    if (r_busy) begin
      w_step_dir  = r_dir;
      w_step_mode = r_mode;
    end else begin
      w_step_dir  = dir;
      w_step_mode = mode;
    end
  end

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_q    (r_q),
    .i_dir  (w_step_dir),
    .i_mode (w_step_mode),
    .i_sin  (sin),
    .o_q    (w_next_q),
    .o_bit  (w_out_bit)
  );

  // Register update: load > sequence step > start > ena > hold.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_q    <= {WIDTH{1'b0}};
      r_sout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= {AW{1'b0}};
      r_dir  <= DIR_RIGHT;
      r_mode <= MODE_LOGIC;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        // Abort any sequence silently; sout keeps its last value.
        r_q    <= data;
        r_busy <= 1'b0;
        r_cnt  <= {AW{1'b0}};
      end else if (r_busy) begin
        r_q    <= w_next_q;
        r_sout <= w_out_bit;
        r_cnt  <= r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (start) begin
        // q is untouched on the start edge; a zero count completes at once.
        r_dir  <= dir;
        r_mode <= mode;
        r_cnt  <= w_amt_sat;
        r_busy <= (w_amt_sat != {AW{1'b0}});
        r_done <= (w_amt_sat == {AW{1'b0}});
      end else if (ena) begin
        r_q    <= w_next_q;
        r_sout <= w_out_bit;
      end
    end
  end

  assign q    = r_q;
  assign sout = r_sout;
  assign busy = r_busy;
  assign done = r_done;

endmodule : shift_reg_n

// File: tb/tb_shift_reg_n.sv
// Scoreboard bench for shift_reg_n (WIDTH=8). Counted sequences push their
// expected final {sout,q} into a queue; a monitor pops on every done pulse.
module tb_shift_reg_n;
  import shift_pkg::*;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk;
  logic          areset_n;
  logic          load;
  logic [W-1:0]  data;
  logic          ena;
  logic          start;
  logic [AW-1:0] amount;
  logic          dir;
  logic [1:0]    mode;
  logic          sin;
  logic [W-1:0]  q;
  logic          sout;
  logic          busy;
  logic          done;

  int checks;
  int failures;

  logic [8:0] exp_q[$];
  logic       m_sout;

  shift_reg_n #(.WIDTH(W)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .load     (load),
    .data     (data),
    .ena      (ena),
    .start    (start),
    .amount   (amount),
    .dir      (dir),
    .mode     (mode),
    .sin      (sin),
    .q        (q),
    .sout     (sout),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Reference: n-step shift computed in one go from the shift rules; returns {sout,q}.
  function automatic logic [8:0] ref_shift(input logic [7:0] q0, input logic [3:0] amt,
                                           input logic d, input logic [1:0] m,
                                           input logic s, input logic so_prev);
    int n;
    logic [7:0] r;
    logic       o;
    logic signed [7:0] sq;
    logic [15:0] dbl;
    logic rot;
    n = (amt > 4'd8) ? 8 : int'(amt);
    if (n == 0) return {so_prev, q0};
`ifdef SHIFT_ROTATE_EN
    rot = (m == 2'b10);
`else
    rot = 1'b0;
`endif
    sq  = q0;
    dbl = {q0, q0};
    if (d) o = q0[8-n];
    else   o = q0[n-1];
    if (rot) begin
      if (d) begin dbl = dbl << n; r = dbl[15:8]; end
      else   begin dbl = dbl >> n; r = dbl[7:0];  end
    end else if (m == 2'b01) begin
      if (d) r = q0 << n;
      else   r = sq >>> n;
    end else begin
      if (d) r = (q0 << n) | (s ? ((8'h01 << n) - 8'h01) : 8'h00);
      else   r = (q0 >> n) | (s ? ~(8'hFF >> n) : 8'h00);
    end
    return {o, r};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [8:0] e;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 q=%0h", q);
      end else begin
        e = exp_q.pop_front();
        check("seq_result", {7'd0, sout, q}, {7'd0, e});
      end
    end
  end

  task automatic load_val(input logic [7:0] v);
    @(negedge clk);
    load = 1'b1; data = v; start = 1'b0; ena = 1'b0;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Issue a counted shift, optionally poke ena/start mid-sequence, count busy cycles.
  task automatic do_seq(input logic [7:0] q0, input logic [3:0] amt, input logic d,
                        input logic [1:0] m, input logic s, input bit disturb);
    int n;
    logic [8:0] e;
    int exp_n;
    load_val(q0);
    start = 1'b1; amount = amt; dir = d; mode = m; sin = s;
    e = ref_shift(q0, amt, d, m, s, m_sout);
    exp_q.push_back(e);
    m_sout = e[8];
    exp_n = (amt > 4'd8) ? 8 : int'(amt);
    @(negedge clk);
    start = 1'b0; dir = ~d; mode = m ^ 2'b01;
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (disturb && n == 1) begin ena = 1'b1; start = 1'b1; amount = 4'd1; end
      else begin ena = 1'b0; start = 1'b0; end
      @(negedge clk);
    end
    ena = 1'b0; start = 1'b0;
    check("busy_cycles", 16'(n), 16'(exp_n));
  endtask

  initial begin
    logic [7:0] v;
    logic [8:0] e;
    logic d, s;
    logic [1:0] m;
    checks = 0; failures = 0; m_sout = 1'b0;
    areset_n = 1'b0; load = 1'b0; data = '0; ena = 1'b0; start = 1'b0;
    amount = '0; dir = 1'b0; mode = 2'b00; sin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {5'd0, busy, done, sout, q}, 16'h0000);
    areset_n = 1'b1;

    // Legacy single shift.
    load_val(8'hA5);
    check("load_q", {8'd0, q}, 16'h00A5);
    ena = 1'b1; dir = 1'b0; mode = 2'b00; sin = 1'b0;
    @(negedge clk);
    check("ena1", {7'd0, sout, q}, {7'd0, 1'b1, 8'h52});
    @(negedge clk);
    check("ena2", {7'd0, sout, q}, {7'd0, 1'b0, 8'h29});
    ena = 1'b0;
    m_sout = 1'b0;

    // Random single shifts through the ena path.
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom); d = 1'($urandom); m = 2'($urandom); s = 1'($urandom);
      load_val(v);
      ena = 1'b1; dir = d; mode = m; sin = s;
      e = ref_shift(v, 4'd1, d, m, s, m_sout);
      @(negedge clk);
      ena = 1'b0;
      check("ena_rand", {7'd0, sout, q}, {7'd0, e});
      m_sout = e[8];
    end

    // Directed counted shifts.
    do_seq(8'h90, 4'd3, DIR_RIGHT, MODE_ARITH, 1'b0, 1'b0);
    check("arith_q", {8'd0, q}, 16'h00F2);
    do_seq(8'h3C, 4'd4, DIR_LEFT, MODE_ROT, 1'b0, 1'b0);
`ifdef SHIFT_ROTATE_EN
    check("rot_q", {8'd0, q}, 16'h00C3);
`else
    check("rot_q", {8'd0, q}, 16'h00C0);
`endif
    do_seq(8'h5A, 4'd0, DIR_RIGHT, MODE_LOGIC, 1'b1, 1'b0);
    check("zero_q", {8'd0, q}, 16'h005A);
    do_seq(8'h00, 4'd12, DIR_RIGHT, MODE_LOGIC, 1'b1, 1'b0);
    check("sat_q", {8'd0, q}, 16'h00FF);

    // ena/start while busy must not disturb the sequence.
    do_seq(8'hC7, 4'd4, DIR_RIGHT, MODE_LOGIC, 1'b0, 1'b1);
    do_seq(8'h81, 4'd1, DIR_LEFT, MODE_ARITH, 1'b0, 1'b1);

    // Random counted shifts.
    for (int i = 0; i < 16; i++) begin
      do_seq(8'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), bit'($urandom));
    end

    // Abort with load on the second busy cycle.
    load_val(8'hB3);
    start = 1'b1; amount = 4'd5; dir = DIR_RIGHT; mode = MODE_LOGIC; sin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", {15'd0, busy}, 16'h0001);
    load = 1'b1; data = 8'h11;
    @(negedge clk);
    load = 1'b0;
    check("abort_state", {6'd0, busy, sout, q}, {6'd0, 1'b0, 1'b1, 8'h11});
    repeat (8) @(negedge clk);
    m_sout = 1'b1;

    // Asynchronous reset mid-sequence.
    load_val(8'hE6);
    start = 1'b1; amount = 4'd5; dir = DIR_LEFT; mode = MODE_LOGIC; sin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    areset_n = 1'b0;
    #1;
    check("async_reset", {5'd0, busy, done, sout, q}, 16'h0000);
    @(negedge clk);
    areset_n = 1'b1;
    m_sout = 1'b0;
    repeat (10) @(negedge clk);

    // Sequence still works after reset.
    do_seq(8'h96, 4'd2, DIR_LEFT, MODE_LOGIC, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("pending_done", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_shift_reg_n
